// File: rtl/sd_digit_recoder.sv
// Sequential BCD-to-signed-digit recoder for the decimal multiplier.
// Streams one (yi, ysi) selection per partial product, LSD first, then the carry.
module sd_digit_recoder #(
    parameter int NDIG = 16,
    parameter int IW   = $clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] y_bcd,
    output logic              busy,
    output logic              pp_valid,
    input  logic              pp_ready,
    output logic [4:0]        yi,
    output logic              ysi,
    output logic [IW-1:0]     pp_idx,
    output logic              pp_last,
    output logic              err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [4*NDIG-1:0] dig_q, dig_d;
    logic              c_q, c_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              err_q, err_d;

    logic              run;
    logic              last;
    logic              accept;
    logic              any_bad;
    logic [3:0]        d;
    logic [2:0]        mag;
    logic              neg;
    logic              cout;

    assign run    = (state_q == RUN);
    assign last   = (idx_q == IW'(NDIG));
    assign accept = run && pp_ready;

    always_comb begin
        any_bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (y_bcd[4*k +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (accept && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digit value from the head of the shift register plus incoming carry
    always_comb begin
        d    = dig_q[3:0];
        mag  = 3'd0;
        neg  = 1'b0;
        cout = 1'b0;
        if (last) begin
            mag = {2'b00, c_q};
        end else if (d > 4'd9) begin
            mag = 3'd0;
        end else if (d < 4'd5) begin
            mag = d[2:0] + {2'b00, c_q};
        end else begin
            mag  = 3'(4'd10 - d - {3'b000, c_q});
            neg  = 1'b1;
            cout = 1'b1;
        end
    end

    always_comb begin
        dig_d = dig_q;
        c_d   = c_q;
        idx_d = idx_q;
        err_d = err_q;
        if (!run) begin
            if (start) begin
                dig_d = y_bcd;
                c_d   = 1'b0;
                idx_d = '0;
                err_d = any_bad;
            end
        end else if (accept) begin
            if (last) begin
                c_d   = 1'b0;
                idx_d = '0;
            end else begin
                dig_d = {4'b0000, dig_q[4*NDIG-1:4]};
                c_d   = cout;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
            c_q   <= 1'b0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            dig_q <= dig_d;
            c_q   <= c_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        busy     = run;
        pp_valid = run;
        pp_idx   = idx_q;
        pp_last  = run && last;
        err      = err_q;
        for (int i = 0; i < 5; i++) begin
            yi[i] = run && (mag == 3'(i + 1));
        end
        ysi = run && neg && (mag != 3'd0);
    end

endmodule

// File: tb/tb_sd_digit_recoder.sv
// Randomized self-checking bench for sd_digit_recoder (NDIG=4).
// Expected selections come from a signed-digit arithmetic model.
module tb_sd_digit_recoder;

    localparam int NDIG = 4;
    localparam int IW   = $clog2(NDIG + 1);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] y_bcd;
    logic              busy;
    logic              pp_valid;
    logic              pp_ready;
    logic [4:0]        yi;
    logic              ysi;
    logic [IW-1:0]     pp_idx;
    logic              pp_last;
    logic              err;

    int checks   = 0;
    int failures = 0;

    sd_digit_recoder #(.NDIG(NDIG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .y_bcd    (y_bcd),
        .busy     (busy),
        .pp_valid (pp_valid),
        .pp_ready (pp_ready),
        .yi       (yi),
        .ysi      (ysi),
        .pp_idx   (pp_idx),
        .pp_last  (pp_last),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic run_op(input logic [15:0] y, input int stall_idx,
                          input int stall_n, input string nm);
        int ev[NDIG+1];
        int c, dd, cyc, st, idx, obs, sum, dec, p, m;
        bit bad;
        logic [4:0] eyi;
        logic       eys;
        c = 0; bad = 0; dec = 0; p = 1;
        for (int k = 0; k < NDIG; k++) begin
            dd = int'((y >> (4*k)) & 16'hF);
            if (dd > 9) begin
                ev[k] = 0; c = 0; bad = 1;
            end else begin
                ev[k] = dd + c;
                c = 0;
                if (dd >= 5) begin ev[k] = ev[k] - 10; c = 1; end
                dec = dec + dd * p;
            end
            p = p * 10;
        end
        ev[NDIG] = c;
        start = 1'b1; y_bcd = y; pp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; st = 0; sum = 0; p = 1;
        while (idx <= NDIG && cyc < 100) begin
            cyc++;
            m   = (ev[idx] < 0) ? -ev[idx] : ev[idx];
            eyi = (m == 0) ? 5'b0 : 5'(1 << (m - 1));
            eys = (ev[idx] < 0);
            checks++;
            if (pp_valid !== 1'b1 || busy !== 1'b1 || pp_idx !== IW'(idx) ||
                yi !== eyi || ysi !== eys || err !== bad ||
                pp_last !== (idx == NDIG)) begin
                failures++;
                $display("FAIL %s idx%0d: got v=%b b=%b i=%0d yi=%b s=%b l=%b e=%b want i=%0d yi=%b s=%b e=%b",
                         nm, idx, pp_valid, busy, pp_idx, yi, ysi, pp_last, err,
                         idx, eyi, eys, bad);
            end
            obs = 0;
            for (int b = 0; b < 5; b++) if (yi[b]) obs = b + 1;
            if (ysi) obs = -obs;
            if (st < stall_n && idx == stall_idx) begin
                pp_ready = 1'b0;
                st++;
                start = 1'b1;
                y_bcd = ~y;
            end else begin
                pp_ready = 1'b1;
                start = 1'b0;
                y_bcd = y;
                sum = sum + obs * p;
                p = p * 10;
                idx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (cyc !== NDIG + 1 + stall_n || busy !== 1'b0 || pp_valid !== 1'b0 ||
            yi !== 5'b0 || pp_idx !== '0 || pp_last !== 1'b0 || err !== bad) begin
            failures++;
            $display("FAIL %s end: cyc=%0d busy=%b v=%b yi=%b idx=%0d err=%b want cyc=%0d idle err=%b",
                     nm, cyc, busy, pp_valid, yi, pp_idx, err, NDIG + 1 + stall_n, bad);
        end
        if (!bad) begin
            checks++;
            if (sum !== dec) begin
                failures++;
                $display("FAIL %s sum: got %0d want %0d", nm, sum, dec);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; y_bcd = '0; pp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 0 || pp_valid !== 0 || yi !== 0 || ysi !== 0 ||
            pp_idx !== 0 || pp_last !== 0 || err !== 0) begin
            failures++;
            $display("FAIL reset: b=%b v=%b yi=%b s=%b i=%0d l=%b e=%b want all 0",
                     busy, pp_valid, yi, ysi, pp_idx, pp_last, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%b want 0", busy);
        end
    endtask

    task automatic test_vectors();
        run_op(16'h1234, 0, 0, "v1234");
        run_op(16'h9999, 0, 0, "v9999");
        run_op(16'h5555, 0, 0, "v5555");
        run_op(16'h4949, 0, 0, "v4949");
        run_op(16'h0000, 0, 0, "v0000");
    endtask

    task automatic test_stall();
        run_op(16'h4949, 1, 3, "stall4949");
        run_op(16'h8765, 4, 2, "stall_carry");
    endtask

    task automatic test_async_reset();
        start = 1'b1; y_bcd = 16'h5555; pp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        pp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pp_idx !== IW'(2) || pp_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst: idx=%0d v=%b want idx=2 v=1", pp_idx, pp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || pp_valid !== 0 || yi !== 0 || ysi !== 0 ||
            pp_idx !== 0 || pp_last !== 0 || err !== 0) begin
            failures++;
            $display("FAIL async_rst: b=%b v=%b yi=%b s=%b i=%0d l=%b want all 0",
                     busy, pp_valid, yi, ysi, pp_idx, pp_last);
        end
        @(negedge clk);
        rst_n = 1'b1; pp_ready = 1'b1;
        @(negedge clk);
        run_op(16'h1234, 0, 0, "after_rst");
    endtask

    task automatic test_err();
        run_op(16'h12A4, 2, 1, "err12A4");
        run_op(16'h1234, 0, 0, "err_clear");
        run_op(16'hF000, 0, 0, "errF000");
    endtask

    task automatic test_back_to_back();
        run_op(16'h9876, 0, 0, "b2b_a");
        run_op(16'h0509, 0, 0, "b2b_b");
        run_op(16'h4445, 0, 0, "b2b_c");
    endtask

    task automatic test_random();
        logic [15:0] y;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NDIG; k++) begin
                if ($urandom_range(0, 9) == 0)
                    y[4*k +: 4] = 4'($urandom_range(10, 15));
                else
                    y[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            run_op(y, int'($urandom_range(0, NDIG)), int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_async_reset();
        test_err();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
